// File: rtl/seven_seg_scan.sv
// seven_seg_scan: self-scanning multi-digit seven-segment display driver.
//
// The block keeps its own refresh counter and digit scan index. It latches
// the digit-code bus once per frame so that one scan never shows a mix of
// old and new values. Leading-zero suppression is optional. All
// display-facing outputs are active low.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   digits        packed 4-bit codes; digit k = digits[4k+3:4k], digit 0 rightmost
//   dp_mask       bit k lights the decimal point of digit k
//   lz_en         1 = blank leading zeros (digit 0 is always shown)
//   disp_en       0 = all anodes off (scanning continues)
//   segments      segments a..g (index 0 = a), active low, registered
//   dp            decimal point, active low, registered
//   anode_active  one-hot-low anode select, registered
//   digit_idx     index of the digit currently being scanned
//   frame_tick    one-cycle pulse when the scan wraps back to digit 0

module seven_seg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int IDX_W       = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_en,
    input  logic                    disp_en,
    output logic [0:6]              segments,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anode_active,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_tick
);

    localparam int                CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    tick_q, tick_d;
    logic [4*NUM_DIGITS-1:0] snap_dig_q;
    logic [NUM_DIGITS-1:0]   snap_dp_q;
    logic [0:6]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;

    logic                    cnt_tc;
    logic                    wrap;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    zero_run;
    logic [3:0]              cur_code;
    logic                    cur_blank;
    logic                    cur_dp;

    function automatic logic [0:6] seg_decode(input logic [3:0] code);
        logic [0:6] s;
        case (code)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0001100;
            4'd15:   s = 7'b1111110;     // minus sign
            default: s = 7'b1111111;     // 10..13 unused, 14 = blank
        endcase
        return s;
    endfunction

    // Refresh counter and scan index. The snapshot and frame_tick share the
    // edge on which the index wraps back to digit 0.
    always_comb begin
        cnt_tc = (cnt_q == CNT_MAX);
        wrap   = cnt_tc && (idx_q == IDX_MAX);
        cnt_d  = cnt_tc ? '0 : cnt_q + CNT_W'(1);
        idx_d  = idx_q;
        if (cnt_tc) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end
        tick_d = wrap;
    end

    // A digit is a leading zero when it and every digit above it are zero
    // in the snapshot. The zero run is walked from the most significant
    // digit downwards. Any non-zero code, minus and blank included, ends it.
    always_comb begin
        blank    = '0;
        zero_run = lz_en;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (snap_dig_q[4*k +: 4] == 4'd0);
            blank[k] = zero_run;
        end
    end

    // Selects the digit at the current index. The outputs are registered,
    // so they follow digit_idx one cycle later.
    always_comb begin
        cur_code  = '0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        anode_d   = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_code  = snap_dig_q[4*k +: 4];
                cur_blank = blank[k];
                cur_dp    = snap_dp_q[k];
                anode_d[k] = ~disp_en;
            end
        end
        seg_d = cur_blank ? 7'b1111111 : seg_decode(cur_code);
        // The decimal point lights even on a blanked digit when its mask bit is set.
        dp_d  = ~cur_dp;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            tick_q     <= 1'b0;
            snap_dig_q <= '0;
            snap_dp_q  <= '0;
            seg_q      <= 7'b1111111;
            dp_q       <= 1'b1;
            anode_q    <= '1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            anode_q <= anode_d;
            if (wrap) begin
                snap_dig_q <= digits;
                snap_dp_q  <= dp_mask;
            end
        end
    end

    assign segments     = seg_q;
    assign dp           = dp_q;
    assign anode_active = anode_q;
    assign digit_idx    = idx_q;
    assign frame_tick   = tick_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan with 4 digits and a 4-cycle refresh.
module tb_seven_seg_scan;

    localparam int ND  = 4;
    localparam int DIV = 4;

    logic        clk;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        lz_en;
    logic        disp_en;
    logic [0:6]  segments;
    logic        dp;
    logic [3:0]  anode_active;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    seven_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV), .IDX_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .digits       (digits),
        .dp_mask      (dp_mask),
        .lz_en        (lz_en),
        .disp_en      (disp_en),
        .segments     (segments),
        .dp           (dp),
        .anode_active (anode_active),
        .digit_idx    (digit_idx),
        .frame_tick   (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [15:0]     digits;
        logic [3:0]      dp_mask;
        logic            lz_en;
        logic [3:0][6:0] seg;    // seg[d] = expected segments for digit d
        logic [3:0]      dp_n;   // dp_n[d] = expected dp for digit d
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until frame_tick is seen. Returns the number of steps taken.
    task automatic wait_tick(input string name, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_tick && n < 40);
        check({name, " tick seen"}, {31'd0, frame_tick}, 32'd1);
    endtask

    initial begin
        int n;

        vecs[0] = '{16'h4321, 4'b0000, 1'b0,
                    {7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111}, 4'b1111};
        vecs[1] = '{16'h0070, 4'b0000, 1'b1,
                    {7'b1111111, 7'b1111111, 7'b0001111, 7'b0000001}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1,
                    {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'b1111};
        vecs[3] = '{16'hF015, 4'b0010, 1'b1,
                    {7'b1111110, 7'b0000001, 7'b1001111, 7'b0100100}, 4'b1101};
        vecs[4] = '{16'h0000, 4'b1000, 1'b1,
                    {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'b0111};
        vecs[5] = '{16'h9876, 4'b0101, 1'b0,
                    {7'b0001100, 7'b0000000, 7'b0001111, 7'b0100000}, 4'b1010};
        vecs[6] = '{16'h0500, 4'b0000, 1'b1,
                    {7'b1111111, 7'b0100100, 7'b0000001, 7'b0000001}, 4'b1111};
        vecs[7] = '{16'h0000, 4'b0000, 1'b0,
                    {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, 4'b1111};
        vecs[8] = '{16'hBCDE, 4'b0000, 1'b0,
                    {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111}, 4'b1111};

        // Reset held with the inputs toggling.
        rst = 1'b0; digits = 16'h1234; dp_mask = 4'hF; lz_en = 1'b1; disp_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            digits = ~digits;
            check("reset segments", {25'd0, segments}, 32'h7F);
            check("reset anode", {28'd0, anode_active}, 32'hF);
            check("reset dp", {31'd0, dp}, 32'd1);
            check("reset digit_idx", {30'd0, digit_idx}, 32'd0);
            check("reset frame_tick", {31'd0, frame_tick}, 32'd0);
        end

        // The first frame displays the zero snapshot, not the live bus.
        rst = 1'b1; digits = 16'h4321; dp_mask = 4'h0;
        step();
        check("first frame d0 anode", {28'd0, anode_active}, 32'hE);
        check("first frame d0 seg", {25'd0, segments}, 32'b0000001);
        for (int c = 2; c <= 5; c++) step();
        check("first frame d1 anode", {28'd0, anode_active}, 32'hD);
        check("first frame d1 blank", {25'd0, segments}, 32'h7F);
        check("first frame idx", {30'd0, digit_idx}, 32'd1);
        n = 5;
        while (!frame_tick && n < 40) begin
            step();
            n++;
        end
        check("first tick cycle", n, 32'd16);

        // Table vectors: for each one, wait for the frame that captures it, then check the full scan.
        for (int v = 0; v < 9; v++) begin
            digits = vecs[v].digits; dp_mask = vecs[v].dp_mask; lz_en = vecs[v].lz_en;
            wait_tick($sformatf("v%0d", v), n);
            check($sformatf("v%0d tick idx", v), {30'd0, digit_idx}, 32'd0);
            for (int s = 1; s <= 16; s++) begin
                int d;
                d = (s - 1) / 4;
                step();
                check($sformatf("v%0d anode s%0d", v, s), {28'd0, anode_active},
                      {28'd0, ~(4'b0001 << d)});
                check($sformatf("v%0d seg d%0d s%0d", v, d, s), {25'd0, segments},
                      {25'd0, vecs[v].seg[d]});
                check($sformatf("v%0d dp d%0d s%0d", v, d, s), {31'd0, dp},
                      {31'd0, vecs[v].dp_n[d]});
                check($sformatf("v%0d idx s%0d", v, s), {30'd0, digit_idx}, (s / 4) % 4);
                check($sformatf("v%0d frame_tick s%0d", v, s), {31'd0, frame_tick},
                      (s == 16) ? 32'd1 : 32'd0);
            end
        end

        // A change to the digits mid-frame is held off until the next wrap.
        digits = 16'h1111; dp_mask = 4'h0; lz_en = 1'b0;
        wait_tick("snap", n);
        for (int s = 1; s <= 16; s++) begin
            step();
            check($sformatf("snap seg s%0d", s), {25'd0, segments}, 32'b1001111);
            check($sformatf("snap anode s%0d", s), {28'd0, anode_active},
                  {28'd0, ~(4'b0001 << ((s - 1) / 4))});
            if (s == 6) digits = 16'h2222;
        end
        check("snap wrap tick", {31'd0, frame_tick}, 32'd1);
        step();
        check("snap new d0 seg", {25'd0, segments}, 32'b0010010);
        check("snap new d0 anode", {28'd0, anode_active}, 32'hE);

        // disp_en low: anodes go off while the scan keeps running.
        disp_en = 1'b0;
        for (int s = 0; s < 8; s++) begin
            step();
            check($sformatf("disp_en off anode s%0d", s), {28'd0, anode_active}, 32'hF);
        end
        check("disp_en off idx advances", {30'd0, digit_idx}, 32'd2);
        check("disp_en off seg", {25'd0, segments}, 32'b0010010);
        disp_en = 1'b1;
        step();
        check("disp_en on anode d2", {28'd0, anode_active}, 32'hB);

        // Reset asserted while digit 2 is lit.
        rst = 1'b0;
        #1;
        check("mid reset seg", {25'd0, segments}, 32'h7F);
        check("mid reset anode", {28'd0, anode_active}, 32'hF);
        check("mid reset dp", {31'd0, dp}, 32'd1);
        check("mid reset idx", {30'd0, digit_idx}, 32'd0);
        check("mid reset tick", {31'd0, frame_tick}, 32'd0);
        step();
        check("mid reset hold anode", {28'd0, anode_active}, 32'hF);
        check("mid reset hold idx", {30'd0, digit_idx}, 32'd0);
        rst = 1'b1;
        step();
        check("restart anode", {28'd0, anode_active}, 32'hE);
        check("restart idx", {30'd0, digit_idx}, 32'd0);
        check("restart zero snapshot", {25'd0, segments}, 32'b0000001);
        n = 1;
        while (!frame_tick && n < 40) begin
            step();
            n++;
        end
        check("restart tick cycle", n, 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
